// File: rtl/multilane_serializer_pkg.sv
// Shared types and helpers for the multi-lane serializer: FSM state encoding
// and the per-lane even-parity function.
package multilane_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } ser_state_e;

  // Widest lane slice the parity helper accepts; callers zero-extend.
  localparam int unsigned MAX_SLICE_WIDTH = 64;

  function automatic logic even_parity(input logic [MAX_SLICE_WIDTH-1:0] bits_i);
    return ^bits_i;
  endfunction

endpackage

// File: rtl/multilane_serializer_lane.sv
// One serial lane: a SLICE_WIDTH+1 shift register holding the data slice plus
// its parity bit, shifted out MSB- or LSB-first.
module multilane_serializer_lane
  import multilane_serializer_pkg::*;
#(
  parameter int SLICE_WIDTH = 8,
  parameter bit LSB_FIRST   = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic                   shift_i,
  input  logic [SLICE_WIDTH-1:0] slice_i,
  output logic                   bit_o
);

  logic [SLICE_WIDTH:0] sr_q, sr_d;
  logic                 parity;

  // Parity sits just past the last data bit in shift order.
  always_comb begin
    parity = even_parity(MAX_SLICE_WIDTH'(slice_i));
    sr_d   = sr_q;
    if (load_i) begin
      sr_d = LSB_FIRST ? {parity, slice_i} : {slice_i, parity};
    end else if (shift_i) begin
      sr_d = LSB_FIRST ? {1'b0, sr_q[SLICE_WIDTH:1]} : {sr_q[SLICE_WIDTH-1:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign bit_o = LSB_FIRST ? sr_q[0] : sr_q[SLICE_WIDTH];

endmodule

// File: rtl/multilane_serializer.sv
// Stripes a parallel word across NUM_LANES serial lanes with optional parity,
// programmable inter-frame gap and a one-entry holding register.
module multilane_serializer
  import multilane_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LANES  = 4,
  parameter bit LSB_FIRST  = 1'b0,
  parameter bit PARITY_EN  = 1'b0,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] parallel_in_i,
  input  logic                  valid_in_i,
  output logic                  ready_o,
  output logic [NUM_LANES-1:0]  serial_out_o,
  output logic                  enable_o,
  output logic                  start_o
);

  localparam int SLICE_WIDTH = DATA_WIDTH / NUM_LANES;
  localparam int FRAME_LEN   = SLICE_WIDTH + (PARITY_EN ? 1 : 0);
  localparam int CNT_W       = $clog2(FRAME_LEN) + 1;
  localparam int GAP_W       = $clog2(GAP_CYCLES + 1) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  ser_state_e            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;

  logic                  last_bit, last_gap, free_next, xfer, load, shifting;
  logic [DATA_WIDTH-1:0] load_word;
  logic [NUM_LANES-1:0]  lane_bits;

  assign ready_o = !hold_valid_q && !rst_i;

  // A pending word always comes from hold first; ready_o is low while hold is full.
  always_comb begin
    last_bit  = (state_q == ST_SHIFT) && (bit_cnt_q == BIT_LAST);
    last_gap  = (GAP_CYCLES > 0) && (state_q == ST_GAP) && (gap_cnt_q == GAP_LAST);
    free_next = (state_q == ST_IDLE) || (last_bit && (GAP_CYCLES == 0)) || last_gap;
    xfer      = valid_in_i && ready_o;
    load      = free_next && (hold_valid_q || xfer);
    load_word = hold_valid_q ? hold_q : parallel_in_i;
    shifting  = (state_q == ST_SHIFT);
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;

    if (xfer && !free_next) begin
      hold_d       = parallel_in_i;
      hold_valid_d = 1'b1;
    end else if (load && hold_valid_q) begin
      hold_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          bit_cnt_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end else if (load) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (last_gap) begin
          gap_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = load ? ST_SHIFT : ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    multilane_serializer_lane #(
      .SLICE_WIDTH(SLICE_WIDTH),
      .LSB_FIRST  (LSB_FIRST)
    ) u_lane (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (load),
      .shift_i(shifting),
      .slice_i(load_word[gi*SLICE_WIDTH +: SLICE_WIDTH]),
      .bit_o  (lane_bits[gi])
    );
  end

  // Outputs are forced low the moment reset is seen, not one cycle later.
  assign enable_o     = shifting && !rst_i;
  assign start_o      = enable_o && (bit_cnt_q == '0);
  assign serial_out_o = enable_o ? lane_bits : '0;

endmodule
